// File: rtl/fifo_wr_arb.sv
// Three-requester round-robin arbiter feeding one shared FIFO write port.
// A grant is held for a whole burst; the burst ends on last, on BURST_MAX beats, or when the request is withdrawn.
module fifo_wr_arb #(
  parameter int W         = 8,
  parameter int BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [2:0]   last,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  input  logic         fifo_full,
  output logic [2:0]   ack,
  output logic [2:0]   gnt,
  output logic         fifo_we,
  output logic [W-1:0] fifo_in,
  output logic         busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  state_t     state_q, state_d;
  logic [2:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] last_srv_q, last_srv_d;

  logic [1:0] gnt_idx;
  logic [2:0] winner;
  logic [3:0] cnt_inc;

  // Round-robin pick: search starts just after the last served requester.
  function automatic logic [2:0] rr_pick(input logic [1:0] ls, input logic [2:0] r);
    logic [1:0] o0, o1, o2;
    case (ls)
      2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (r[o0])      rr_pick = 3'b001 << o0;
    else if (r[o1]) rr_pick = 3'b001 << o1;
    else if (r[o2]) rr_pick = 3'b001 << o2;
    else            rr_pick = 3'b000;
  endfunction

  always_comb begin
    gnt_idx = 2'd0;
    case (gnt_q)
      3'b010:  gnt_idx = 2'd1;
      3'b100:  gnt_idx = 2'd2;
      default: gnt_idx = 2'd0;
    endcase
  end

  assign winner  = rr_pick(last_srv_q, req);
  assign cnt_inc = cnt_q + 4'd1;

  // Beat acceptance is purely combinational so the requester can advance on the same edge.
  assign ack     = gnt_q & req & {3{~fifo_full}};
  assign fifo_we = |ack;
  assign gnt     = gnt_q;
  assign busy    = busy_q;

  always_comb begin
    fifo_in = '0;
    if (fifo_we) begin
      case (gnt_q)
        3'b001:  fifo_in = din0;
        3'b010:  fifo_in = din1;
        3'b100:  fifo_in = din2;
        default: fifo_in = '0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    last_srv_d = last_srv_q;
    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          state_d = BUSY;
          gnt_d   = winner;
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
        end
      end
      BUSY: begin
        if (!req[gnt_idx]) begin
          state_d    = IDLE;
          gnt_d      = 3'b000;
          busy_d     = 1'b0;
          last_srv_d = gnt_idx;
        end else if (fifo_we) begin
          cnt_d = cnt_inc;
          if (last[gnt_idx] || (cnt_inc == BURST_LIM)) begin
            state_d    = IDLE;
            gnt_d      = 3'b000;
            busy_d     = 1'b0;
            last_srv_d = gnt_idx;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 3'b000;
      busy_q     <= 1'b0;
      cnt_q      <= 4'd0;
      last_srv_q <= 2'd2;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      last_srv_q <= last_srv_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed, table-driven bench for fifo_wr_arb with per-cycle invariant checks.
module tb_fifo_wr_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req, last;
  logic [7:0] din0, din1, din2;
  logic       fifo_full;
  logic [2:0] ack, gnt;
  logic       fifo_we;
  logic [7:0] fifo_in;
  logic       busy;

  int total = 0;
  int bad   = 0;

  fifo_wr_arb #(.W(8), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .din0(din0), .din1(din1), .din2(din2), .fifo_full(fifo_full),
    .ack(ack), .gnt(gnt), .fifo_we(fifo_we), .fifo_in(fifo_in), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] last;
    logic       full;
    logic [7:0] d0;
    logic [2:0] e_ack;
    logic [2:0] e_gnt;
    logic       e_we;
    logic [7:0] e_in;
    logic       e_busy;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [2:0] ls,
                              input logic fl, input logic [7:0] d0, input logic [2:0] ea,
                              input logic [2:0] eg, input logic ew, input logic [7:0] ei,
                              input logic eb, input string nm);
    vec_t v;
    v.rst = r; v.req = rq; v.last = ls; v.full = fl; v.d0 = d0;
    v.e_ack = ea; v.e_gnt = eg; v.e_we = ew; v.e_in = ei; v.e_busy = eb; v.name = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Inputs go in just after the edge, outputs are compared mid-cycle, then one edge elapses.
  task automatic apply(input vec_t v);
    rst = v.rst; req = v.req; last = v.last; fifo_full = v.full; din0 = v.d0;
    #2;
    chk({v.name, ".ack"},  32'(ack),     32'(v.e_ack));
    chk({v.name, ".gnt"},  32'(gnt),     32'(v.e_gnt));
    chk({v.name, ".we"},   32'(fifo_we), 32'(v.e_we));
    chk({v.name, ".in"},   32'(fifo_in), 32'(v.e_in));
    chk({v.name, ".busy"}, 32'(busy),    32'(v.e_busy));
    $display("vec %s req=%b full=%b ack=%b gnt=%b we=%b in=%h busy=%b",
             v.name, v.req, v.full, ack, gnt, fifo_we, fifo_in, busy);
    @(posedge clk);
    #1;
  endtask

  // Invariants checked every cycle: one-hot grant, ack only when granted, no write when full.
  always @(negedge clk) begin
    chk("inv.onehot", 32'($countones(gnt) <= 1), 32'd1);
    chk("inv.ack_gnt", 32'(ack & ~gnt), 32'd0);
    chk("inv.we_full", 32'(fifo_we & fifo_full), 32'd0);
  end

  initial begin
    logic [7:0] dat [3];
    dat[0] = 8'hA0; dat[1] = 8'hB1; dat[2] = 8'hC2;
    din1 = 8'hB1; din2 = 8'hC2;

    // Basic two-beat burst ending on last
    vecs.push_back(mk(0, 3'b001, 3'b000, 0, 8'h11, 3'b000, 3'b000, 0, 8'h00, 0, "r28_idle"));
    vecs.push_back(mk(0, 3'b001, 3'b000, 0, 8'h11, 3'b001, 3'b001, 1, 8'h11, 1, "r28_b1"));
    vecs.push_back(mk(0, 3'b001, 3'b001, 0, 8'h22, 3'b001, 3'b001, 1, 8'h22, 1, "r28_b2"));
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 8'h22, 3'b000, 3'b000, 0, 8'h00, 0, "r28_end"));
    // Reset restores last_srv=2, then all three requesters rotate with full-length bursts
    vecs.push_back(mk(1, 3'b111, 3'b000, 0, 8'hA0, 3'b000, 3'b000, 0, 8'h00, 0, "r29_rst"));
    vecs.push_back(mk(0, 3'b111, 3'b000, 0, 8'hA0, 3'b000, 3'b000, 0, 8'h00, 0, "r29_idle"));
    for (int g = 0; g < 3; g++) begin
      for (int b = 0; b < 4; b++)
        vecs.push_back(mk(0, 3'b111, 3'b000, 0, 8'hA0, 3'(1 << g), 3'(1 << g), 1, dat[g], 1,
                          $sformatf("r29_g%0d_b%0d", g, b)));
      vecs.push_back(mk(0, 3'b111, 3'b000, 0, 8'hA0, 3'b000, 3'b000, 0, 8'h00, 0,
                        $sformatf("r29_gap%0d", g)));
    end
    vecs.push_back(mk(0, 3'b111, 3'b000, 0, 8'hA0, 3'b001, 3'b001, 1, 8'hA0, 1, "r29_wrap"));

    rst = 1'b1; req = 3'b111; last = 3'b000; fifo_full = 1'b0; din0 = 8'hA0;
    #1;
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.ack", 32'(ack), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.we", 32'(fifo_we), 32'd0);
    chk("rst.in", 32'(fifo_in), 32'd0);
    chk("rst.gnt2", 32'(gnt), 32'd0);

    foreach (vecs[i]) apply(vecs[i]);

    // Stall on fifo_full mid-burst; last during the stall must not end the burst
    apply(mk(1, 3'b010, 3'b000, 0, 8'hA0, 3'b000, 3'b000, 0, 8'h00, 0, "r30_rst"));
    apply(mk(0, 3'b010, 3'b000, 0, 8'hA0, 3'b000, 3'b000, 0, 8'h00, 0, "r30_idle"));
    apply(mk(0, 3'b010, 3'b000, 0, 8'hA0, 3'b010, 3'b010, 1, 8'hB1, 1, "r30_b1"));
    for (int s = 0; s < 3; s++)
      apply(mk(0, 3'b010, 3'b010, 1, 8'hA0, 3'b000, 3'b010, 0, 8'h00, 1, $sformatf("r30_stall%0d", s)));
    for (int b = 2; b <= 4; b++)
      apply(mk(0, 3'b010, 3'b000, 0, 8'hA0, 3'b010, 3'b010, 1, 8'hB1, 1, $sformatf("r30_b%0d", b)));
    apply(mk(0, 3'b100, 3'b000, 0, 8'hA0, 3'b000, 3'b000, 0, 8'h00, 0, "r30_end"));

    // Requester 2 withdraws after one beat; requester 0 must win next
    apply(mk(0, 3'b101, 3'b000, 0, 8'hA0, 3'b100, 3'b100, 1, 8'hC2, 1, "r31_b1"));
    apply(mk(0, 3'b001, 3'b000, 0, 8'hA0, 3'b000, 3'b100, 0, 8'h00, 1, "r31_drop"));
    apply(mk(0, 3'b011, 3'b000, 0, 8'hA0, 3'b000, 3'b000, 0, 8'h00, 0, "r31_idle"));
    apply(mk(0, 3'b011, 3'b000, 0, 8'hA0, 3'b001, 3'b001, 1, 8'hA0, 1, "r31_gnt0"));

    // Asynchronous reset between edges aborts the burst immediately
    req = 3'b011; last = 3'b000; fifo_full = 1'b0;
    #1;
    chk("r32_pre.ack", 32'(ack), 32'b001);
    #1;
    rst = 1'b1;
    #1;
    chk("r32_async.gnt", 32'(gnt), 32'd0);
    chk("r32_async.we", 32'(fifo_we), 32'd0);
    chk("r32_async.ack", 32'(ack), 32'd0);
    chk("r32_async.busy", 32'(busy), 32'd0);
    $display("vec r32_async gnt=%b we=%b ack=%b busy=%b", gnt, fifo_we, ack, busy);
    @(posedge clk);
    #1;
    apply(mk(0, 3'b110, 3'b000, 0, 8'hA0, 3'b000, 3'b000, 0, 8'h00, 0, "r32_idle"));
    apply(mk(0, 3'b110, 3'b000, 0, 8'hA0, 3'b010, 3'b010, 1, 8'hB1, 1, "r32_gnt1"));

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
